// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table, all-off pattern, and the
// nibble-to-glyph helper used by the hex decoder and the scan driver.
// Glyph bit order is a..g from MSB to LSB, active-low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG7_OFF = 7'h7F;

  localparam seg_t SEG7_GLYPH [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return SEG7_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Table lookup through the shared package helper
  always_comb begin
    glyph = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit hex seven-segment scan driver.
// Double-buffered display word, one digit per PRESCALE clocks, with a
// one-cycle all-off anode gap at each digit change. Outputs are registered.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank,
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PCNT_W = $clog2(PRESCALE);
  localparam int BUF_W  = 5 * NUM_DIGITS;

  // Buffer layout: {dp bits, hex nibbles}
  logic [PCNT_W-1:0]     pcnt;
  logic [IDX_W-1:0]      idx;
  logic [BUF_W-1:0]      shadow;
  logic [BUF_W-1:0]      disp;
  logic                  tick;
  logic                  frame_wrap;
  logic [3:0]            nib;
  logic                  cur_dp;
  logic [6:0]            glyph;
  logic                  lz_off;
  logic [NUM_DIGITS-1:0] an_next;

  assign tick       = (pcnt == PCNT_W'(PRESCALE - 1));
  assign frame_wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  // Prescaler and digit index; reset restarts the scan at digit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  // Shadow captures on load; display copies only at frame wrap, and a load
  // on the wrap cycle bypasses the shadow so it shows immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      disp   <= '0;
    end else begin
      if (load) shadow <= {dp_in, value};
      if (frame_wrap) disp <= load ? {dp_in, value} : shadow;
    end
  end

  // Select the current digit's nibble and decimal point
  always_comb begin
    nib    = '0;
    cur_dp = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib    = disp[4*i +: 4];
        cur_dp = disp[4*NUM_DIGITS + i];
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble (nib),
    .glyph  (glyph)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic [IDX_W-1:0] msd;

  // Highest nonzero nibble position; digit 0 when the word is all zero
  always_comb begin
    msd = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (disp[4*i +: 4] != 4'h0) msd = IDX_W'(i);
    end
  end

  assign lz_off = (idx > msd) && !cur_dp;
`else
  assign lz_off = 1'b0;
`endif

  // Anode enable for the current slot; pcnt==0 is the inter-digit gap
  always_comb begin
    an_next = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((pcnt != '0) && !blank && (idx == IDX_W'(i))) an_next[i] = 1'b0;
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG7_OFF;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= lz_off ? SEG7_OFF : glyph;
      dp  <= lz_off ? 1'b1 : ~cur_dp;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, PRESCALE=4.
// Expectations follow SEG7_LZ_BLANK_EN if it is defined for the build.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int PS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  an;

  int tests = 0;
  int fails = 0;
  int pos   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .dp_in (dp_in),
    .load  (load),
    .blank (blank),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (pos %0d)", tag, obs, exp, pos);
    end
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h01; 4'h1: return 7'h4F; 4'h2: return 7'h12; 4'h3: return 7'h06;
      4'h4: return 7'h4C; 4'h5: return 7'h24; 4'h6: return 7'h20; 4'h7: return 7'h0F;
      4'h8: return 7'h00; 4'h9: return 7'h04; 4'hA: return 7'h08; 4'hB: return 7'h60;
      4'hC: return 7'h31; 4'hD: return 7'h42; 4'hE: return 7'h30; default: return 7'h38;
    endcase
  endfunction

  function automatic logic [6:0] seg_exp(input logic [15:0] shown, input logic [3:0] sdp, input int d);
    logic [3:0] n;
    n = shown[4*d +: 4];
`ifdef SEG7_LZ_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < ND; i++) if (shown[4*i +: 4] != 4'h0) msd = i;
      if (d > msd && !sdp[d]) return 7'h7F;
    end
`endif
    return glyph_of(n);
  endfunction

  // One clock: sample at negedge and compare against the slot model
  task automatic step(input logic [15:0] shown, input logic [3:0] sdp);
    int d;
    int p;
    logic [3:0] an_e;
    @(negedge clk);
    d = pos / 4;
    p = pos % 4;
    an_e = (p == 0 || blank) ? 4'hF : ~(4'b0001 << d);
    check("an", {12'b0, an}, {12'b0, an_e});
    if (an_e != 4'hF) begin
      check("seg", {9'b0, seg}, {9'b0, seg_exp(shown, sdp, d)});
      check("dp", {15'b0, dp}, {15'b0, ~sdp[d]});
    end
    pos = (pos + 1) % 16;
  endtask

  initial begin
    reset = 1'b1; value = '0; dp_in = '0; load = 1'b0; blank = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", {9'b0, seg}, 16'h007F);
    check("rst_an",  {12'b0, an}, 16'h000F);
    check("rst_dp",  {15'b0, dp}, 16'h0001);

    // Release reset with a load of 1234 on the first frame
    reset = 1'b0; value = 16'h1234; load = 1'b1; pos = 0;
    for (int k = 0; k < 16; k++) begin
      step(16'h0000, 4'b0000);
      load = 1'b0;
    end
    for (int k = 0; k < 16; k++) step(16'h1234, 4'b0000);

    // Mid-frame load: current frame unchanged, next frame shows ABCD
    for (int k = 0; k < 16; k++) begin
      step(16'h1234, 4'b0000);
      if (k == 5) begin value = 16'hABCD; dp_in = 4'b0100; load = 1'b1; end
      else load = 1'b0;
    end
    for (int k = 0; k < 16; k++) step(16'hABCD, 4'b0100);

    // Blank for 6 cycles; scan keeps running underneath
    for (int k = 0; k < 16; k++) begin
      step(16'hABCD, 4'b0100);
      blank = (k >= 2 && k < 8);
    end

    // Load 0050 for leading-zero behaviour
    for (int k = 0; k < 16; k++) begin
      step(16'hABCD, 4'b0100);
      if (k == 0) begin value = 16'h0050; dp_in = 4'b0000; load = 1'b1; end
      else load = 1'b0;
    end

    // Load on the wrap cycle itself takes effect at once
    for (int k = 0; k < 16; k++) begin
      step(16'h0050, 4'b0000);
      if (k == 14) begin value = 16'h8000; load = 1'b1; end
      else load = 1'b0;
    end
    for (int k = 0; k < 16; k++) step(16'h8000, 4'b0000);

    // Reset while idx=2
    for (int k = 0; k < 10; k++) step(16'h8000, 4'b0000);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_seg", {9'b0, seg}, 16'h007F);
    check("midrst_an",  {12'b0, an}, 16'h000F);
    check("midrst_dp",  {15'b0, dp}, 16'h0001);
    reset = 1'b0; pos = 0;
    for (int k = 0; k < 8; k++) step(16'h0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
